reg_wb_sched: RTL and testbench
===============================

// Module: reg_wb_sched
// PURPOSE
//  Write-port scheduler and scoreboard in front of the 32x64 register file. The file has
//  one write port, shared by in-order pipeline writeback (WB) and a long-latency unit (LLU:
//  multiply/divide/load-miss).
//  - Buffers LLU results and tracks registers with an outstanding LLU write.
//  - Stalls issue on RAW/WAW hazards against those registers.
//  - Keeps the LLU from being starved by continuous WB traffic.
// PARAMETERS
//  FIFO_DEPTH     4   LLU result buffer entries (power of 2, >=2)
//  MAX_OUTSTAND   8   max LLU ops in flight (issued, not yet written to the file)
//  STARVE_LIMIT   4   consecutive cycles a non-empty FIFO may lose arbitration to WB
// PORTS
//  CLK            in   1   clock
//  RST_N          in   1   asynchronous reset, active-low
//  ISSUE_VALID    in   1   decode presents an instruction
//  ISSUE_LONG     in   1   instruction targets the LLU
//  ISSUE_RS1      in   5   source register 1
//  ISSUE_RS2      in   5   source register 2
//  ISSUE_RD       in   5   destination register
//  ISSUE_STALL    out  1   instruction not accepted this cycle (combinational)
//  PIPE_WB_VALID  in   1   pipeline WB write request
//  PIPE_WB_REG    in   5   WB destination
//  PIPE_WB_DATA   in   64  WB data
//  PIPE_HOLD      out  1   registered; pipeline must not assert PIPE_WB_VALID this cycle
//  LLU_VALID      in   1   LLU result valid
//  LLU_READY      out  1   FIFO not full
//  LLU_REG        in   5   LLU destination
//  LLU_DATA       in   64  LLU result data
//  REG_WRITE_C    out  1   register file write enable
//  WR_REG         out  5   register file write index
//  WR_DATA        out  64  register file write data
// BEHAVIOUR
//  Reset (RST_N low, async):
//  - REG_WRITE_C, PIPE_HOLD = 0; WR_REG = 0; WR_DATA = 0.
//  - Scoreboard cleared, FIFO empty (LLU_READY = 1), outstanding count = 0, starve count = 0.
//  - Reset mid-operation discards buffered LLU results and in-flight tracking.
//  Issue and hazards:
//  - pend[31:0] marks registers with an LLU write in flight. Index 31 (XZR) is never set
//    and never causes a stall.
//  - ISSUE_STALL = ISSUE_VALID & (pend[RS1] | pend[RS2] | pend[RD] |
//    (ISSUE_LONG & outstanding == MAX_OUTSTAND)).
//  - Accepted = ISSUE_VALID & !ISSUE_STALL. An accepted ISSUE_LONG with RD != 31 sets
//    pend[RD] and increments outstanding.
//  - An LLU op to XZR still counts as outstanding. Its result drains from the FIFO but is
//    not written.
//  LLU capture:
//  - Handshake LLU_VALID & LLU_READY pushes {LLU_REG, LLU_DATA}.
//  - LLU_VALID while the FIFO is full: no push, and the LLU holds its data.
//  Arbitration:
//  - WB wins by default. The FIFO head wins when WB is idle, or when PIPE_HOLD = 1.
//  - starve_cnt increments each cycle the FIFO is non-empty and loses to WB, and clears on
//    a FIFO grant.
//  - When starve_cnt reaches STARVE_LIMIT, PIPE_HOLD = 1 for exactly the next cycle, and
//    the FIFO head is granted in that cycle.
//  - PIPE_WB_VALID while PIPE_HOLD = 1 is a protocol error (assertion). The data is dropped.
//  Write port:
//  - The granted request is registered onto REG_WRITE_C/WR_REG/WR_DATA, giving 1-cycle
//    latency from grant to file write.
//  - Grants targeting reg 31 produce REG_WRITE_C = 0.
//  - A FIFO grant pops the FIFO, clears pend[reg], and decrements outstanding, all in the
//    grant cycle.
//  Simultaneous events:
//  - Pop and push in the same cycle while the FIFO is full are not allowed: LLU_READY is
//    based on the current count.
//  - Pop and push while the FIFO is partially full leave the count unchanged.
//  - Clear of pend[r] and an issue reading r in the same cycle: the issue still sees
//    pend[r] = 1 and stalls one more cycle. There is no bypass.
//  - Increment and decrement of outstanding in the same cycle leave it unchanged.
//  - WAW between WB and a pending LLU write cannot occur, because issue stalls on pend[RD].
// STRUCTURE
//  - legv8_pkg: typedef logic [4:0] reg_idx_t; typedef logic [63:0] xword_t;
//    localparam reg_idx_t XZR = 5'd31; typedef struct packed {reg_idx_t r; xword_t d;}
//    wb_req_t.
//  - One sub-module: sync_fifo #(.T(wb_req_t), .DEPTH(FIFO_DEPTH)) holds LLU results
//    (full/empty flags, count).
//  - Scoreboard, counters, arbiter and output register live in reg_wb_sched.
// TESTING
//  1. Reset: drive traffic, then pull RST_N low mid-burst -> all outputs 0 immediately,
//     LLU_READY = 1, no write after release.
//  2. RAW: issue LONG RD=5, then issue RS1=5 -> stall until the LLU result for X5 is
//     granted; released the cycle after the grant; WR_REG=5 written once.
//  3. XZR: issue LONG RD=31, then RS1=31 -> no stall; the LLU result for 31 pops with
//     REG_WRITE_C = 0; WB to X31 never writes.
//  4. Starvation: WB valid every cycle, one LLU result queued ->
//     PIPE_HOLD=1 after STARVE_LIMIT=4 lost cycles; FIFO entry written the cycle after
//     the hold.
//  5. Backpressure: 4 LLU results with WB saturating -> LLU_READY=0 at count 4; 5th
//     result held, accepted after the first pop; nothing lost or reordered.
//  6. Outstanding cap: 8 LONG issues without results -> 9th LONG stalls; a non-long
//     issue with a clean scoreboard proceeds.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared register-file types for the LEGv8 core: register index, data word and
// the write request that flows through the write-port scheduler.
package legv8_pkg;
    typedef logic [4:0]  reg_idx_t;
    typedef logic [63:0] xword_t;

    localparam reg_idx_t XZR = 5'd31;

    typedef struct packed {
        reg_idx_t r;
        xword_t   d;
    } wb_req_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with count and full/empty flags; DEPTH must be a power of 2.
// Push when full and pop when empty are ignored.
module sync_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       i_push,
    input  T                           i_din,
    input  logic                       i_pop,
    output T                           o_dout,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    T              r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: only entries below r_count are ever read.
    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wptr] <= i_din;
    end
endmodule

// File: rtl/reg_wb_sched.sv
// Register-file write-port scheduler: arbitrates pipeline writeback against buffered
// long-latency results, tracks in-flight LLU destinations and stalls hazardous issue.
module reg_wb_sched
    import legv8_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int MAX_OUTSTAND = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        ISSUE_VALID,
    input  logic        ISSUE_LONG,
    input  logic [4:0]  ISSUE_RS1,
    input  logic [4:0]  ISSUE_RS2,
    input  logic [4:0]  ISSUE_RD,
    output logic        ISSUE_STALL,
    input  logic        PIPE_WB_VALID,
    input  logic [4:0]  PIPE_WB_REG,
    input  logic [63:0] PIPE_WB_DATA,
    output logic        PIPE_HOLD,
    input  logic        LLU_VALID,
    output logic        LLU_READY,
    input  logic [4:0]  LLU_REG,
    input  logic [63:0] LLU_DATA,
    output logic        REG_WRITE_C,
    output logic [4:0]  WR_REG,
    output logic [63:0] WR_DATA
);
    localparam int OW  = $clog2(MAX_OUTSTAND+1);
    localparam int SW  = $clog2(STARVE_LIMIT+1);
    localparam int FCW = $clog2(FIFO_DEPTH+1);
    localparam logic [OW-1:0] OUT_MAX    = OW'(MAX_OUTSTAND);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [31:0]    r_pend;
    logic [OW-1:0]  r_outstand;
    logic [SW-1:0]  r_starve;
    logic           r_hold;
    logic           r_wr_en;
    reg_idx_t       r_wr_reg;
    xword_t         r_wr_data;

    wb_req_t        w_llu_req;
    wb_req_t        w_wb_req;
    wb_req_t        w_head;
    wb_req_t        w_gnt_req;
    logic           w_full;
    logic           w_empty;
    logic [FCW-1:0] w_fifo_cnt;
    logic           w_push;
    logic           w_stall;
    logic           w_long_acc;
    logic           w_fifo_gnt;
    logic           w_wb_gnt;
    logic [31:0]    w_pend_set;
    logic [31:0]    w_pend_clr;
    logic [SW-1:0]  w_starve_nxt;

    // Hazard check reads the registered scoreboard only, so a clear in this
    // cycle still stalls the reader for one more cycle.
    assign w_stall    = ISSUE_VALID & (r_pend[ISSUE_RS1] | r_pend[ISSUE_RS2] |
                        r_pend[ISSUE_RD] | (ISSUE_LONG & (r_outstand == OUT_MAX)));
    assign w_long_acc = ISSUE_VALID & ~w_stall & ISSUE_LONG;

    assign w_llu_req  = '{r: LLU_REG, d: LLU_DATA};
    assign w_wb_req   = '{r: PIPE_WB_REG, d: PIPE_WB_DATA};
    assign w_push     = LLU_VALID & ~w_full;

    sync_fifo #(.T(wb_req_t), .DEPTH(FIFO_DEPTH)) u_llu_fifo (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .i_push  (w_push),
        .i_din   (w_llu_req),
        .i_pop   (w_fifo_gnt),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_fifo_cnt)
    );

    // WB wins unless it is idle or held off; a held-off WB request is dropped.
    assign w_fifo_gnt = ~w_empty & (~PIPE_WB_VALID | r_hold);
    assign w_wb_gnt   = PIPE_WB_VALID & ~r_hold;
    assign w_gnt_req  = w_fifo_gnt ? w_head : w_wb_req;

    always_comb begin
        w_pend_set = '0;
        w_pend_clr = '0;
        if (w_long_acc && (ISSUE_RD != XZR)) w_pend_set[ISSUE_RD] = 1'b1;
        if (w_fifo_gnt)                      w_pend_clr[w_head.r] = 1'b1;
    end

    always_comb begin
        w_starve_nxt = r_starve;
        if (w_fifo_gnt)
            w_starve_nxt = '0;
        else if (!w_empty && w_wb_gnt && (r_starve != STARVE_MAX))
            w_starve_nxt = r_starve + SW'(1);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pend     <= '0;
            r_outstand <= '0;
            r_starve   <= '0;
            r_hold     <= 1'b0;
        end else begin
            r_pend   <= (r_pend & ~w_pend_clr) | w_pend_set;
            r_starve <= w_starve_nxt;
            r_hold   <= (w_starve_nxt == STARVE_MAX);
            case ({w_long_acc, w_fifo_gnt})
                2'b10:   r_outstand <= r_outstand + OW'(1);
                2'b01:   r_outstand <= r_outstand - OW'(1);
                default: r_outstand <= r_outstand;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_en   <= 1'b0;
            r_wr_reg  <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= (w_fifo_gnt | w_wb_gnt) & (w_gnt_req.r != XZR);
            if (w_fifo_gnt || w_wb_gnt) begin
                r_wr_reg  <= w_gnt_req.r;
                r_wr_data <= w_gnt_req.d;
            end
        end
    end

    assign ISSUE_STALL = w_stall;
    assign LLU_READY   = ~w_full;
    assign PIPE_HOLD   = r_hold;
    assign REG_WRITE_C = r_wr_en;
    assign WR_REG      = r_wr_reg;
    assign WR_DATA     = r_wr_data;

    a_no_wb_on_hold: assert property (@(posedge CLK) disable iff (!RST_N)
        !(r_hold && PIPE_WB_VALID));
    a_fifo_bound: assert property (@(posedge CLK) disable iff (!RST_N)
        w_fifo_cnt <= FCW'(FIFO_DEPTH));
endmodule

// File: tb/tb_reg_wb_sched.sv
// Directed scenarios plus a randomized run for reg_wb_sched, checked against a
// queue-based reference model of the write port, scoreboard and starvation rule.
module tb_reg_wb_sched;
    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 8;
    localparam int STARVE  = 4;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        ISSUE_VALID, ISSUE_LONG;
    logic [4:0]  ISSUE_RS1, ISSUE_RS2, ISSUE_RD;
    logic        ISSUE_STALL;
    logic        PIPE_WB_VALID;
    logic [4:0]  PIPE_WB_REG;
    logic [63:0] PIPE_WB_DATA;
    logic        PIPE_HOLD;
    logic        LLU_VALID, LLU_READY;
    logic [4:0]  LLU_REG;
    logic [63:0] LLU_DATA;
    logic        REG_WRITE_C;
    logic [4:0]  WR_REG;
    logic [63:0] WR_DATA;

    reg_wb_sched #(.FIFO_DEPTH(DEPTH), .MAX_OUTSTAND(MAX_OUT), .STARVE_LIMIT(STARVE)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .ISSUE_VALID(ISSUE_VALID), .ISSUE_LONG(ISSUE_LONG),
        .ISSUE_RS1(ISSUE_RS1), .ISSUE_RS2(ISSUE_RS2), .ISSUE_RD(ISSUE_RD),
        .ISSUE_STALL(ISSUE_STALL),
        .PIPE_WB_VALID(PIPE_WB_VALID), .PIPE_WB_REG(PIPE_WB_REG), .PIPE_WB_DATA(PIPE_WB_DATA),
        .PIPE_HOLD(PIPE_HOLD),
        .LLU_VALID(LLU_VALID), .LLU_READY(LLU_READY), .LLU_REG(LLU_REG), .LLU_DATA(LLU_DATA),
        .REG_WRITE_C(REG_WRITE_C), .WR_REG(WR_REG), .WR_DATA(WR_DATA)
    );

    always #5 CLK = ~CLK;

    typedef struct packed { logic [4:0] r; logic [63:0] d; } ent_t;

    int checks = 0;
    int errors = 0;

    // Reference model: pending set, in-flight count, LLU buffer as a queue,
    // count of consecutive lost arbitrations and the resulting hold.
    bit [31:0]   m_pend;
    int          m_out;
    ent_t        m_fifo[$];
    int          m_lost;
    bit          m_hold;
    bit          e_we;
    logic [4:0]  e_reg;
    logic [63:0] e_data;

    logic [4:0]  llu_todo[$];
    bit          llu_acc;
    logic        last_stall;
    int          wr_cnt = 0;

    bit          lv_cur;
    logic [4:0]  lr_cur;
    logic [63:0] ld_cur;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_pend = '0; m_out = 0; m_fifo.delete(); m_lost = 0; m_hold = 0;
        e_we = 0; llu_todo.delete(); lv_cur = 0;
    endtask

    // One clock: entered and left 1 ns after a rising edge.
    task automatic cyc(input bit iv, input bit lg, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input bit wv, input logic [4:0] wr,
                       input logic [63:0] wd, input bit lv, input logic [4:0] lr,
                       input logic [63:0] ld);
        bit   stall, ready, fg, wg;
        ent_t h;
        ISSUE_VALID = iv; ISSUE_LONG = lg; ISSUE_RS1 = r1; ISSUE_RS2 = r2; ISSUE_RD = rd;
        PIPE_WB_VALID = wv; PIPE_WB_REG = wr; PIPE_WB_DATA = wd;
        LLU_VALID = lv; LLU_REG = lr; LLU_DATA = ld;
        #1;
        stall = iv && (m_pend[r1] || m_pend[r2] || m_pend[rd] || (lg && m_out == MAX_OUT));
        check("issue_stall", 64'(ISSUE_STALL), 64'(stall));
        last_stall = ISSUE_STALL;
        ready = (m_fifo.size() < DEPTH);
        check("llu_ready", 64'(LLU_READY), 64'(ready));
        llu_acc = lv && ready;
        fg = (m_fifo.size() != 0) && (!wv || m_hold);
        wg = wv && !m_hold;
        e_we = 0;
        if (fg) begin
            h = m_fifo.pop_front();
            e_we = (h.r != 5'd31); e_reg = h.r; e_data = h.d;
            m_pend[h.r] = 1'b0; m_out--; m_lost = 0;
        end else if (wg) begin
            e_we = (wr != 5'd31); e_reg = wr; e_data = wd;
            if (m_fifo.size() != 0) m_lost++;
        end
        m_hold = (m_lost == STARVE);
        if (iv && !stall && lg) begin
            if (rd != 5'd31) m_pend[rd] = 1'b1;
            m_out++;
            llu_todo.push_back(rd);
        end
        if (llu_acc) m_fifo.push_back('{r: lr, d: ld});
        @(posedge CLK); #1;
        check("reg_write", 64'(REG_WRITE_C), 64'(e_we));
        if (e_we) begin
            check("wr_reg", 64'(WR_REG), 64'(e_reg));
            check("wr_data", WR_DATA, e_data);
        end
        check("pipe_hold", 64'(PIPE_HOLD), 64'(m_hold));
        if (REG_WRITE_C === 1'b1) wr_cnt++;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear before any edge.
    task automatic do_reset();
        #2;
        RST_N = 1'b0;
        PIPE_WB_VALID = 0; LLU_VALID = 0;
        ISSUE_VALID = 1; ISSUE_LONG = 1; ISSUE_RS1 = 5'd1; ISSUE_RS2 = 5'd2; ISSUE_RD = 5'd3;
        #1;
        check("rst_we", 64'(REG_WRITE_C), 64'd0);
        check("rst_wr_reg", 64'(WR_REG), 64'd0);
        check("rst_wr_data", WR_DATA, 64'd0);
        check("rst_hold", 64'(PIPE_HOLD), 64'd0);
        check("rst_llu_ready", 64'(LLU_READY), 64'd1);
        check("rst_no_stall", 64'(ISSUE_STALL), 64'd0);
        ISSUE_VALID = 0; ISSUE_LONG = 0;
        model_clear();
        @(posedge CLK); #1;
        RST_N = 1'b1;
    endtask

    initial begin
        int          n, w0, idx, k5;
        logic [63:0] d7;
        logic [63:0] bp_d[5];
        bit          riv, rlg, rwv;
        logic [4:0]  r1, r2, rd, wr;

        RST_N = 1'b0;
        ISSUE_VALID = 0; ISSUE_LONG = 0; ISSUE_RS1 = 0; ISSUE_RS2 = 0; ISSUE_RD = 0;
        PIPE_WB_VALID = 0; PIPE_WB_REG = 0; PIPE_WB_DATA = 0;
        LLU_VALID = 0; LLU_REG = 0; LLU_DATA = 0;
        model_clear();
        @(posedge CLK); #1;
        do_reset();

        // 1: reset in the middle of traffic with buffered results and pending regs
        cyc(1, 1, 0, 0, 5'd1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 5'd2, 1, 5'd3, 64'h33, 1, 5'd1, 64'h1111);
        cyc(0, 0, 0, 0, 0, 1, 5'd4, 64'h44, 1, 5'd2, 64'h2222);
        cyc(0, 0, 0, 0, 0, 1, 5'd4, 64'h45, 0, 0, 0);
        do_reset();
        w0 = wr_cnt;
        repeat (4) idle();
        check("rst_no_write_after", 64'(wr_cnt - w0), 64'd0);

        // 2: RAW on a pending LLU destination
        do_reset();
        w0 = wr_cnt;
        cyc(1, 1, 0, 0, 5'd5, 0, 0, 0, 0, 0, 0);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            cyc(1, 0, 5'd5, 0, 5'd6, 0, 0, 0, k == 0, 5'd5, 64'hA5A5_0000_5555_0005);
            if (!last_stall) break;
            n++;
        end
        check("raw_stall_cycles", 64'(n), 64'd2);
        idle(); idle();
        check("raw_x5_writes", 64'(wr_cnt - w0), 64'd1);

        // 3: XZR destination never stalls and never writes
        do_reset();
        w0 = wr_cnt;
        cyc(1, 1, 0, 0, 5'd31, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 5'd31, 5'd31, 5'd31, 0, 0, 0, 1, 5'd31, 64'hDEAD);
        check("xzr_no_stall", 64'(last_stall), 64'd0);
        idle();
        cyc(0, 0, 0, 0, 0, 1, 5'd31, 64'hBEEF, 0, 0, 0);
        idle(); idle();
        check("xzr_writes", 64'(wr_cnt - w0), 64'd0);

        // 4: starvation hold under continuous WB
        do_reset();
        d7 = {$urandom(), $urandom()};
        cyc(1, 1, 0, 0, 5'd7, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 5'd2, 64'h20, 1, 5'd7, d7);
        n = 0;
        while (PIPE_HOLD !== 1'b1 && n < 20) begin
            cyc(0, 0, 0, 0, 0, 1, 5'd2, {$urandom(), $urandom()}, 0, 0, 0);
            n++;
        end
        check("starve_lost_cycles", 64'(n), 64'd4);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("starve_we", 64'(REG_WRITE_C), 64'd1);
        check("starve_reg", 64'(WR_REG), 64'd7);
        check("starve_data", WR_DATA, d7);
        check("starve_hold_one_cycle", 64'(PIPE_HOLD), 64'd0);

        // 5: FIFO backpressure with WB saturating (WB to X31 so only LLU writes count)
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bp_d[i] = {$urandom(), $urandom()};
            cyc(1, 1, 0, 0, 5'(10 + i), 0, 0, 0, 0, 0, 0);
        end
        w0 = wr_cnt; idx = 0; k5 = -1;
        for (int k = 0; k < 20 && idx < 5; k++) begin
            cyc(0, 0, 0, 0, 0, PIPE_HOLD !== 1'b1, 5'd31, 64'h0, 1, 5'(10 + idx), bp_d[idx]);
            if (llu_acc) begin
                if (idx == 4) k5 = k;
                idx++;
            end
            if (k == 3) check("bp_ready_full", 64'(LLU_READY), 64'd0);
        end
        check("bp_fifth_accept_cycle", 64'(k5), 64'd6);
        repeat (8) idle();
        check("bp_llu_writes", 64'(wr_cnt - w0), 64'd5);

        // 6: outstanding cap
        do_reset();
        for (int i = 0; i < MAX_OUT; i++) begin
            cyc(1, 1, 0, 0, 5'(1 + i), 0, 0, 0, 0, 0, 0);
            check("cap_issue", 64'(last_stall), 64'd0);
        end
        cyc(1, 1, 0, 0, 5'd20, 0, 0, 0, 0, 0, 0);
        check("cap_ninth_stall", 64'(last_stall), 64'd1);
        cyc(1, 0, 5'd20, 5'd21, 5'd22, 0, 0, 0, 0, 0, 0);
        check("cap_short_ok", 64'(last_stall), 64'd0);
        cyc(1, 0, 5'd3, 0, 5'd23, 0, 0, 0, 0, 0, 0);
        check("cap_pend_rs1", 64'(last_stall), 64'd1);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 800; c++) begin
            riv = ($urandom_range(0, 1) == 1);
            rlg = ($urandom_range(0, 2) == 0);
            r1  = 5'($urandom_range(0, 7));
            r2  = 5'($urandom_range(0, 7));
            rd  = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            rwv = ($urandom_range(0, 3) != 0) && !m_hold;
            wr  = 5'($urandom_range(0, 31));
            if (!lv_cur && llu_todo.size() != 0 && $urandom_range(0, 2) == 0) begin
                lv_cur = 1; lr_cur = llu_todo[0]; ld_cur = {$urandom(), $urandom()};
            end
            cyc(riv, rlg, r1, r2, rd, rwv, wr, {$urandom(), $urandom()}, lv_cur, lr_cur, ld_cur);
            if (llu_acc) begin
                lv_cur = 0;
                void'(llu_todo.pop_front());
            end
        end
        n = 0;
        while ((llu_todo.size() != 0 || lv_cur || m_fifo.size() != 0) && n < 300) begin
            if (!lv_cur && llu_todo.size() != 0) begin
                lv_cur = 1; lr_cur = llu_todo[0]; ld_cur = {$urandom(), $urandom()};
            end
            cyc(0, 0, 0, 0, 0, 0, 0, 0, lv_cur, lr_cur, ld_cur);
            if (llu_acc) begin
                lv_cur = 0;
                void'(llu_todo.pop_front());
            end
            n++;
        end
        check("drain_within_bound", 64'(n < 300), 64'd1);
        for (int i = 0; i < MAX_OUT; i++) cyc(1, 1, 5'(i), 5'(i + 8), 5'(i + 16), 0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
